noncoh_sum_pair: RTL and testbench
==================================

Name: noncoh_sum_pair

Overview:
Reader-side partner of the coherent accumulator in the acquire engine. It takes one coherent-RAM word, which holds a positive/negative frequency pair in exp10 format, and converts each complex value to an approximate amplitude. It adds each amplitude into the matching noncoherent-RAM word and returns the result for write-back. On the last noncoherent round it also tracks the peak amplitude, with its correlator index and frequency sign, for the acquisition search.

Parameters:
NONCOH_WIDTH, 24, unsigned width of one noncoherent accumulator (per frequency)
INDEX_WIDTH, 10, width of correlator/code-phase index

Ports:
clk  input  1  system clock
rst_b  input  1  reset, synchronous, active-low
coh_valid  input  1  coherent word and aligned inputs valid this cycle
coh_data_in  input  48  [47:24] positive freq, [23:0] negative freq; each {I[9:0], Q[9:0], exp[3:0]}
noncoh_data_in  input  2*NONCOH_WIDTH  previous noncoh RAM word, {pos, neg}, aligned with coh_valid
first_noncoh  input  1  ignore noncoh_data_in (treat as 0), aligned with coh_valid
last_noncoh  input  1  final noncoherent round; enable peak search, aligned with coh_valid
cor_index  input  INDEX_WIDTH  index of this word, aligned with coh_valid
peak_clear  input  1  clear peak tracker
noncoh_valid  output  1  noncoh_data_out valid
noncoh_data_out  output  2*NONCOH_WIDTH  accumulated {pos, neg} for write-back
peak_valid  output  1  at least one candidate loaded since clear/reset
peak_value  output  NONCOH_WIDTH  largest accumulated amplitude
peak_index  output  INDEX_WIDTH  cor_index of peak
peak_neg  output  1  1 = peak from negative frequency

Behaviour:
- Exp10 decoding: I and Q are signed two's complement mantissas; value = mantissa * 2^exp. Magnitudes are 11-bit unsigned, so |-512| = 512.
- Amplitude per frequency: amp = max(|I|,|Q|) + ((3*min(|I|,|Q|)) >> 3), truncating. The result fits in 11 bits.
- Scaling: scaled = amp << exp, computed at full width. If scaled >= 2^NONCOH_WIDTH, it saturates to all ones.
- Accumulation: sum = scaled + (first_noncoh ? 0 : old). The sum saturates at 2^NONCOH_WIDTH-1 and never wraps.
- Pipeline:
  - S1, on the edge where coh_valid is sampled: register the abs max/min, exp, the noncoh operands, and the flags/index.
  - S2: register amp and scaled.
  - S3: register the saturated sums.
  - noncoh_valid is asserted exactly 3 cycles after coh_valid. Full throughput: one word per cycle, back-to-back, with no stalls and no backpressure.
- Data registers hold their values when no valid is in that stage. The valid bits form a shift chain.
- Peak tracker, one cycle after noncoh_valid:
  - Updates only for words tagged last_noncoh.
  - Candidate is the larger of pos/neg; on a tie, pos wins.
  - Update if !peak_valid or candidate > peak_value (strict), so the earliest index is kept on equality.
  - On update, load value, index, and peak_neg, and set peak_valid.
- peak_clear: zeroes all peak outputs and peak_valid. If peak_clear coincides with a candidate, the clear applies first and the candidate is loaded as the new peak.
- Reset (rst_b low at an edge): all outputs and pipeline registers go to 0, and in-flight words are discarded. The first valid after reset release appears 3 cycles later.

Decomposition:
- Shared acquire package: exp10 field widths/offsets (MANT_WIDTH=10, EXP_WIDTH=4, EXP10_WORD=24) and the amplitude coefficient constant (3/8 as a multiply by 3 and a shift by 3).
- One sub-module, exp10_amplitude. It is combinational: abs, max/min, alpha-max-beta-min, and shift with saturation. It is instantiated twice (pos/neg) between S1 and S2.

Test Plan:
1. Basic accumulate:
   - Stimulus: pos I=3, Q=-4, exp=2; neg I=-512, Q=0, exp=0; first_noncoh=1.
   - Response: 3 cycles later, noncoh_valid=1 with pos=20, neg=512.
2. Accumulate:
   - Stimulus: same coherent word, first_noncoh=0, noncoh_data_in={100, 7}.
   - Response: out={120, 519}. With first_noncoh=1 and the same inputs: {20, 512}.
3. Saturation:
   - Stimulus: I=511, Q=511, exp=15.
   - Response: pos=0xFFFFFF.
   - Stimulus: old=0xFFFFF0 plus amp 32.
   - Response: 0xFFFFFF, with no wrap.
4. Peak tracking:
   - Stimulus, back-to-back with last_noncoh=1: index 5 pos=40; index 6 neg=90; index 7 pos=90.
   - Response: peak_value=90, peak_index=6, peak_neg=1.
   - Stimulus: last_noncoh=0 word with amp 500.
   - Response: peak unchanged.
5. peak_clear:
   - Stimulus: peak_clear asserted in the same cycle as a candidate of 30 at index 9.
   - Response: peak_value=30, peak_index=9.
   - Stimulus: peak_clear alone.
   - Response: all peak outputs 0, peak_valid=0.
6. Reset:
   - Stimulus: rst_b low for 1 cycle while 2 words are in flight.
   - Response: noncoh_valid is never asserted for them, and all outputs are 0. A new word after reset release gives noncoh_valid at +3 cycles.

Source files
------------

// File: rtl/noncoh_sum_pair_pkg.sv
// Shared acquire definitions: exp10 field layout, the 3/8 amplitude coefficient,
// and helpers used by the noncoherent summation path.
package noncoh_sum_pair_pkg;

    localparam int MANT_WIDTH = 10;
    localparam int EXP_WIDTH  = 4;
    localparam int EXP10_WORD = 24;

    // {I, Q, exp}: exp in the low bits, then Q, then I on top
    localparam int Q_LSB = EXP_WIDTH;
    localparam int I_LSB = EXP_WIDTH + MANT_WIDTH;

    // |-512| needs one more bit than the mantissa
    localparam int MAG_WIDTH = MANT_WIDTH + 1;

    // beta = 3/8, applied as (min * 3) >> 3
    localparam int AMP_COEF_MUL   = 3;
    localparam int AMP_COEF_SHIFT = 3;

    typedef struct packed {
        logic [MAG_WIDTH-1:0] mag_max;
        logic [MAG_WIDTH-1:0] mag_min;
        logic [EXP_WIDTH-1:0] exp;
    } mag_pair_t;

    function automatic logic [MAG_WIDTH-1:0] mant_abs(input logic [MANT_WIDTH-1:0] m);
        logic [MAG_WIDTH-1:0] ext;
        ext = {m[MANT_WIDTH-1], m};
        return m[MANT_WIDTH-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/noncoh_sum_pair_exp10_amplitude.sv
// Combinational exp10 amplitude slice: the front half feeds the S1 register
// (abs, max/min), the back half turns registered max/min/exp into a saturated scaled amplitude.
module exp10_amplitude
    import noncoh_sum_pair_pkg::*;
#(
    parameter int NONCOH_WIDTH = 24
) (
    input  logic [EXP10_WORD-1:0]   word,
    output mag_pair_t               mag,
    input  mag_pair_t               mag_q,
    output logic [NONCOH_WIDTH-1:0] scaled
);

    localparam int AMP_CALC_W = MAG_WIDTH + 2;
    localparam int SHIFT_W    = AMP_CALC_W + (1 << EXP_WIDTH) - 1;

    logic [MAG_WIDTH-1:0]  abs_i;
    logic [MAG_WIDTH-1:0]  abs_q;
    logic [AMP_CALC_W-1:0] min3;
    logic [AMP_CALC_W-1:0] amp;
    logic [SHIFT_W-1:0]    shifted;

    assign abs_i = mant_abs(word[I_LSB +: MANT_WIDTH]);
    assign abs_q = mant_abs(word[Q_LSB +: MANT_WIDTH]);

    always_comb begin
        mag.exp = word[EXP_WIDTH-1:0];
        if (abs_i >= abs_q) begin
            mag.mag_max = abs_i;
            mag.mag_min = abs_q;
        end else begin
            mag.mag_max = abs_q;
            mag.mag_min = abs_i;
        end
    end

    // Shift is done wide enough for exp=15 so overflow is detected, not lost
    always_comb begin
        min3    = AMP_CALC_W'(mag_q.mag_min) * AMP_CALC_W'(AMP_COEF_MUL);
        amp     = AMP_CALC_W'(mag_q.mag_max) + (min3 >> AMP_COEF_SHIFT);
        shifted = SHIFT_W'(amp) << mag_q.exp;
        scaled  = (|shifted[SHIFT_W-1:NONCOH_WIDTH]) ? '1 : shifted[NONCOH_WIDTH-1:0];
    end

endmodule

// File: rtl/noncoh_sum_pair.sv
// Three-stage noncoherent accumulator for a {pos, neg} exp10 pair with a peak
// tracker over the last noncoherent round. Lane 1 is positive frequency, lane 0 negative.
module noncoh_sum_pair
    import noncoh_sum_pair_pkg::*;
#(
    parameter int NONCOH_WIDTH = 24,
    parameter int INDEX_WIDTH  = 10
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      coh_valid,
    input  logic [2*EXP10_WORD-1:0]   coh_data_in,
    input  logic [2*NONCOH_WIDTH-1:0] noncoh_data_in,
    input  logic                      first_noncoh,
    input  logic                      last_noncoh,
    input  logic [INDEX_WIDTH-1:0]    cor_index,
    input  logic                      peak_clear,
    output logic                      noncoh_valid,
    output logic [2*NONCOH_WIDTH-1:0] noncoh_data_out,
    output logic                      peak_valid,
    output logic [NONCOH_WIDTH-1:0]   peak_value,
    output logic [INDEX_WIDTH-1:0]    peak_index,
    output logic                      peak_neg
);

    mag_pair_t               mag_next    [2];
    logic [NONCOH_WIDTH-1:0] old_next    [2];
    logic [NONCOH_WIDTH-1:0] scaled_next [2];
    logic [NONCOH_WIDTH-1:0] sum_next    [2];

    logic                    v1_reg, v2_reg, v3_reg;
    mag_pair_t               mag_reg     [2];
    logic [NONCOH_WIDTH-1:0] old1_reg    [2];
    logic [NONCOH_WIDTH-1:0] scaled_reg  [2];
    logic [NONCOH_WIDTH-1:0] old2_reg    [2];
    logic [NONCOH_WIDTH-1:0] sum_reg     [2];
    logic                    last1_reg, last2_reg, last3_reg;
    logic [INDEX_WIDTH-1:0]  idx1_reg, idx2_reg, idx3_reg;

    logic                    peak_valid_reg;
    logic [NONCOH_WIDTH-1:0] peak_value_reg;
    logic [INDEX_WIDTH-1:0]  peak_index_reg;
    logic                    peak_neg_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [NONCOH_WIDTH:0] sum_wide;

            exp10_amplitude #(
                .NONCOH_WIDTH(NONCOH_WIDTH)
            ) u_amp (
                .word   (coh_data_in[gi*EXP10_WORD +: EXP10_WORD]),
                .mag    (mag_next[gi]),
                .mag_q  (mag_reg[gi]),
                .scaled (scaled_next[gi])
            );

            // first_noncoh is folded in at S1 so later stages never see stale RAM data
            assign old_next[gi] = first_noncoh ? '0 : noncoh_data_in[gi*NONCOH_WIDTH +: NONCOH_WIDTH];
            assign sum_wide     = {1'b0, scaled_reg[gi]} + {1'b0, old2_reg[gi]};
            assign sum_next[gi] = sum_wide[NONCOH_WIDTH] ? '1 : sum_wide[NONCOH_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            v3_reg    <= 1'b0;
            last1_reg <= 1'b0;
            last2_reg <= 1'b0;
            last3_reg <= 1'b0;
            idx1_reg  <= '0;
            idx2_reg  <= '0;
            idx3_reg  <= '0;
            for (int k = 0; k < 2; k++) begin
                mag_reg[k]    <= '0;
                old1_reg[k]   <= '0;
                scaled_reg[k] <= '0;
                old2_reg[k]   <= '0;
                sum_reg[k]    <= '0;
            end
        end else begin
            v1_reg <= coh_valid;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
            if (coh_valid) begin
                last1_reg <= last_noncoh;
                idx1_reg  <= cor_index;
                for (int k = 0; k < 2; k++) begin
                    mag_reg[k]  <= mag_next[k];
                    old1_reg[k] <= old_next[k];
                end
            end
            if (v1_reg) begin
                last2_reg <= last1_reg;
                idx2_reg  <= idx1_reg;
                for (int k = 0; k < 2; k++) begin
                    scaled_reg[k] <= scaled_next[k];
                    old2_reg[k]   <= old1_reg[k];
                end
            end
            if (v2_reg) begin
                last3_reg <= last2_reg;
                idx3_reg  <= idx2_reg;
                for (int k = 0; k < 2; k++) begin
                    sum_reg[k] <= sum_next[k];
                end
            end
        end
    end

    logic                    cand_ok;
    logic                    cand_neg;
    logic [NONCOH_WIDTH-1:0] cand_value;

    // Ties go to the positive frequency
    assign cand_ok    = v3_reg && last3_reg;
    assign cand_neg   = sum_reg[0] > sum_reg[1];
    assign cand_value = cand_neg ? sum_reg[0] : sum_reg[1];

    // A coincident clear makes the candidate win unconditionally
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            peak_valid_reg <= 1'b0;
            peak_value_reg <= '0;
            peak_index_reg <= '0;
            peak_neg_reg   <= 1'b0;
        end else if (cand_ok && (peak_clear || !peak_valid_reg || cand_value > peak_value_reg)) begin
            peak_valid_reg <= 1'b1;
            peak_value_reg <= cand_value;
            peak_index_reg <= idx3_reg;
            peak_neg_reg   <= cand_neg;
        end else if (peak_clear) begin
            peak_valid_reg <= 1'b0;
            peak_value_reg <= '0;
            peak_index_reg <= '0;
            peak_neg_reg   <= 1'b0;
        end
    end

    assign noncoh_valid    = v3_reg;
    assign noncoh_data_out = {sum_reg[1], sum_reg[0]};
    assign peak_valid      = peak_valid_reg;
    assign peak_value      = peak_value_reg;
    assign peak_index      = peak_index_reg;
    assign peak_neg        = peak_neg_reg;

endmodule

// File: tb/tb_noncoh_sum_pair.sv
// Directed and randomized checks of noncoh_sum_pair against an arithmetic
// reference model (delay line of expected words plus a peak tracker).
module tb_noncoh_sum_pair;

    localparam int     NW  = 24;
    localparam int     IW  = 10;
    localparam longint SAT = 64'd16777215;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            coh_valid;
    logic [47:0]     coh_data_in;
    logic [2*NW-1:0] noncoh_data_in;
    logic            first_noncoh;
    logic            last_noncoh;
    logic [IW-1:0]   cor_index;
    logic            peak_clear;
    logic            noncoh_valid;
    logic [2*NW-1:0] noncoh_data_out;
    logic            peak_valid;
    logic [NW-1:0]   peak_value;
    logic [IW-1:0]   peak_index;
    logic            peak_neg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noncoh_sum_pair #(.NONCOH_WIDTH(NW), .INDEX_WIDTH(IW)) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .coh_valid       (coh_valid),
        .coh_data_in     (coh_data_in),
        .noncoh_data_in  (noncoh_data_in),
        .first_noncoh    (first_noncoh),
        .last_noncoh     (last_noncoh),
        .cor_index       (cor_index),
        .peak_clear      (peak_clear),
        .noncoh_valid    (noncoh_valid),
        .noncoh_data_out (noncoh_data_out),
        .peak_valid      (peak_valid),
        .peak_value      (peak_value),
        .peak_index      (peak_index),
        .peak_neg        (peak_neg)
    );

    // Reference model: expected word per pipeline position (1..3) and the peak state
    bit            mv [4];
    logic [47:0]   md [4];
    bit            ml [4];
    logic [IW-1:0] mi [4];
    bit            pv;
    logic [NW-1:0] pval;
    logic [IW-1:0] pidx;
    bit            pneg;

    function automatic int mag(input logic [9:0] m);
        int v;
        v = int'($signed(m));
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [23:0] lane(input logic [23:0] w, input logic [23:0] old, input bit first);
        int i, q, e, mx, mn;
        longint s;
        i  = mag(w[23:14]);
        q  = mag(w[13:4]);
        e  = int'(w[3:0]);
        mx = (i > q) ? i : q;
        mn = (i > q) ? q : i;
        s  = longint'(mx + (3 * mn) / 8) * (longint'(1) << e);
        if (s > SAT) s = SAT;
        if (!first) s = s + longint'(old);
        if (s > SAT) s = SAT;
        return s[23:0];
    endfunction

    function automatic logic [23:0] mkw(input int i, input int q, input int e);
        logic [31:0] vi, vq, ve;
        vi = i; vq = q; ve = e;
        return {vi[9:0], vq[9:0], ve[3:0]};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        logic [NW-1:0] cp, cn;
        @(posedge clk);
        if (!rst_b) begin
            for (int k = 0; k < 4; k++) begin
                mv[k] = 0; md[k] = '0; ml[k] = 0; mi[k] = '0;
            end
            pv = 0; pval = '0; pidx = '0; pneg = 0;
        end else begin
            if (peak_clear) begin
                pv = 0; pval = '0; pidx = '0; pneg = 0;
            end
            if (mv[3] && ml[3]) begin
                cp = md[3][47:24];
                cn = md[3][23:0];
                if (!pv || cn > pval || cp > pval) begin
                    pv   = 1;
                    pneg = (cn > cp);
                    pval = pneg ? cn : cp;
                    pidx = mi[3];
                end
            end
            for (int k = 3; k > 1; k--) begin
                mv[k] = mv[k-1]; md[k] = md[k-1]; ml[k] = ml[k-1]; mi[k] = mi[k-1];
            end
            mv[1] = coh_valid;
            md[1] = {lane(coh_data_in[47:24], noncoh_data_in[47:24], first_noncoh),
                     lane(coh_data_in[23:0],  noncoh_data_in[23:0],  first_noncoh)};
            ml[1] = last_noncoh;
            mi[1] = cor_index;
        end
        #1;
        check("noncoh_valid", 48'(noncoh_valid), 48'(mv[3]));
        if (mv[3]) check("noncoh_data", noncoh_data_out, md[3]);
        check("peak_valid", 48'(peak_valid), 48'(pv));
        check("peak_value", 48'(peak_value), 48'(pval));
        check("peak_index", 48'(peak_index), 48'(pidx));
        check("peak_neg",   48'(peak_neg),   48'(pneg));
    endtask

    task automatic send(input logic [23:0] pw, input logic [23:0] nw, input logic [47:0] old,
                        input bit first, input bit last, input int idx);
        coh_valid      = 1'b1;
        coh_data_in    = {pw, nw};
        noncoh_data_in = old;
        first_noncoh   = first;
        last_noncoh    = last;
        cor_index      = IW'(idx);
        tick();
        coh_valid      = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0; coh_valid = 1'b0; coh_data_in = '0; noncoh_data_in = '0;
        first_noncoh = 1'b0; last_noncoh = 1'b0; cor_index = '0; peak_clear = 1'b0;
        tick(); tick();
        check("reset_data", noncoh_data_out, 48'd0);
        rst_b = 1'b1;
        tick();

        // basic accumulate
        send(mkw(3, -4, 2), mkw(-512, 0, 0), 48'd0, 1, 0, 1);
        tick(); tick();
        check("basic", noncoh_data_out, {24'd20, 24'd512});

        // accumulate onto old, then same with first_noncoh
        send(mkw(3, -4, 2), mkw(-512, 0, 0), {24'd100, 24'd7}, 0, 0, 2);
        send(mkw(3, -4, 2), mkw(-512, 0, 0), {24'd100, 24'd7}, 1, 0, 3);
        tick();
        check("accum", noncoh_data_out, {24'd120, 24'd519});
        tick();
        check("accum_first", noncoh_data_out, {24'd20, 24'd512});

        // saturation in the shift and in the add
        send(mkw(511, 511, 15), mkw(0, 0, 0), 48'd0, 1, 0, 4);
        send(mkw(32, 0, 0), mkw(0, 0, 0), {24'hFFFFF0, 24'd0}, 0, 0, 4);
        tick();
        check("sat_shift", noncoh_data_out, {24'hFFFFFF, 24'd0});
        tick();
        check("sat_add", noncoh_data_out, {24'hFFFFFF, 24'd0});

        // peak tracking, equal value keeps the earlier index
        send(mkw(40, 0, 0), mkw(0, 0, 0), 48'd0, 1, 1, 5);
        send(mkw(0, 0, 0), mkw(90, 0, 0), 48'd0, 1, 1, 6);
        send(mkw(90, 0, 0), mkw(0, 0, 0), 48'd0, 1, 1, 7);
        repeat (4) tick();
        check("peak4", {peak_value, 13'd0, peak_index, peak_neg}, {24'd90, 13'd0, 10'd6, 1'b1});
        send(mkw(500, 0, 0), mkw(0, 0, 0), 48'd0, 1, 0, 8);
        repeat (4) tick();
        check("peak_not_last", {peak_value, 13'd0, peak_index, peak_neg}, {24'd90, 13'd0, 10'd6, 1'b1});

        // clear coinciding with a candidate, then clear alone
        send(mkw(30, 0, 0), mkw(0, 0, 0), 48'd0, 1, 1, 9);
        tick(); tick();
        peak_clear = 1'b1;
        tick();
        peak_clear = 1'b0;
        check("clear_cand", {peak_valid, peak_value, peak_index}, {1'b1, 24'd30, 10'd9});
        peak_clear = 1'b1;
        tick();
        peak_clear = 1'b0;
        check("clear_alone", {peak_valid, peak_value, peak_index, peak_neg}, 36'd0);

        // reset with two words in flight
        send(mkw(100, 0, 0), mkw(0, 0, 0), 48'd0, 1, 1, 10);
        send(mkw(200, 0, 0), mkw(0, 0, 0), 48'd0, 1, 1, 11);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        check("rst_flush", {noncoh_valid, noncoh_data_out, peak_valid, peak_value, peak_index, peak_neg},
              84'd0);
        repeat (3) tick();
        send(mkw(12, 5, 1), mkw(0, 7, 0), 48'd0, 1, 0, 12);
        tick(); tick();
        check("post_rst_valid", 48'(noncoh_valid), 48'd1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            coh_valid      = ($urandom_range(0, 3) != 0);
            coh_data_in    = {16'($urandom), 32'($urandom)};
            noncoh_data_in = {24'($urandom), 24'($urandom)};
            if ($urandom_range(0, 7) == 0) noncoh_data_in[47:40] = 8'hFF;
            first_noncoh   = ($urandom_range(0, 3) == 0);
            last_noncoh    = ($urandom_range(0, 1) == 1);
            cor_index      = IW'($urandom);
            peak_clear     = ($urandom_range(0, 31) == 0);
            tick();
        end
        coh_valid  = 1'b0;
        peak_clear = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
